// File: rtl/wb_slave_mem_if.sv
// wb_slave_mem_if: Wishbone classic bus bundle between a master and wb_slave_mem.
// Signals: cyc_i, stb_i, we_i, adr_i, dat_i (master -> slave); dat_o, ack_o (slave -> master).
// err_o exists only when WB_SLAVE_ERR_EN is defined.
interface wb_slave_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  cyc_i;
   logic                  stb_i;
   logic                  we_i;
   logic [ADDR_WIDTH-1:0] adr_i;
   logic [DATA_WIDTH-1:0] dat_i;
   logic [DATA_WIDTH-1:0] dat_o;
   logic                  ack_o;
`ifdef WB_SLAVE_ERR_EN
   logic                  err_o;
   modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input dat_o, ack_o, err_o);
   modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o, err_o);
`else
   modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
   modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
`endif
endinterface

// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic slave memory with programmable wait states.
// Ports: clk, rst (async, active-low), bus (wb_slave_mem_if.slave), access_count (acked transfers).
// Optional macro WB_SLAVE_ERR_EN: addresses >= DEPTH answer with err_o instead of aliasing.
module wb_slave_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   wb_slave_mem_if.slave        bus,
   output logic [15:0]          access_count
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;
   localparam state_t S_FIRST = WAIT_CYCLES > 0 ? S_WAIT : S_ACK;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   state_t                state, state_nxt;
   logic [3:0]            wcnt;
   logic [AW-1:0]         lat_adr;
   logic                  lat_we;
   logic [DATA_WIDTH-1:0] lat_dat;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  req;
   logic                  lat_oor;
   assign req = bus.cyc_i & bus.stb_i;
`ifdef WB_SLAVE_ERR_EN
   logic adr_oor;
   assign adr_oor = bus.adr_i >= ADDR_WIDTH'(DEPTH);
   always_ff @(posedge clk or negedge rst)
      if (!rst) lat_oor <= 1'b0;
      else if (state == S_IDLE && req) lat_oor <= adr_oor;
`else
   // Upper address bits are ignored: out-of-range addresses alias into the array.
   logic unused_adr;
   assign unused_adr = ^bus.adr_i[ADDR_WIDTH-1:AW];
   assign lat_oor = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = req ? S_FIRST : S_IDLE;
         S_WAIT:  state_nxt = !req ? S_IDLE : (wcnt == 4'd0 ? S_ACK : S_WAIT);
         S_ACK:   state_nxt = S_RELEASE;
         default: state_nxt = bus.stb_i ? S_RELEASE : S_IDLE;
      endcase
   end
   // ack/err and the memory access fire on the edge that leaves S_ACK,
   // giving WAIT_CYCLES+1 edges of latency from the sampling edge.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wcnt         <= 4'd0;
         lat_adr      <= '0;
         lat_we       <= 1'b0;
         lat_dat      <= '0;
         bus.ack_o    <= 1'b0;
         bus.dat_o    <= '0;
         access_count <= 16'd0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         bus.ack_o <= state == S_ACK && !lat_oor;
         if (state == S_IDLE && req) begin
            lat_adr <= bus.adr_i[AW-1:0];
            lat_we  <= bus.we_i;
            lat_dat <= bus.dat_i;
            wcnt    <= WAIT_LOAD;
         end else if (state == S_WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
         if (state == S_ACK && !lat_oor) begin
            if (lat_we) mem[lat_adr] <= lat_dat;
            else bus.dat_o <= mem[lat_adr];
            access_count <= access_count + 16'd1;
         end
         if (state == S_ACK && lat_oor) bus.dat_o <= '0;
      end
`ifdef WB_SLAVE_ERR_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) bus.err_o <= 1'b0;
      else bus.err_o <= state == S_ACK && lat_oor;
`endif
endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: directed checks of wb_slave_mem with WAIT_CYCLES=1 and WAIT_CYCLES=4 instances.
module tb_wb_slave_mem;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cnt_a, cnt_b;
   logic        err_a;
   int          nvec = 0, nerr = 0;
   int          acks_a = 0, acks_b = 0, errs_a = 0;
   logic [31:0] rd, exp4;
   int          lat;
   logic        ack2;
   wb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) a ();
   wb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b ();
   wb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .bus(a.slave), .access_count(cnt_a));
   wb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .bus(b.slave), .access_count(cnt_b));
   always #5 clk = ~clk;
`ifdef WB_SLAVE_ERR_EN
   assign err_a = a.err_o;
`else
   assign err_a = 1'b0;
`endif
   always @(posedge a.ack_o) acks_a++;
   always @(posedge b.ack_o) acks_b++;
   always @(posedge err_a) errs_a++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic xfer(input logic w, input logic [31:0] adr, input logic [31:0] dat,
                       output logic [31:0] r, output int l, output logic ack_again);
      @(negedge clk);
      a.cyc_i = 1'b1; a.stb_i = 1'b1; a.we_i = w; a.adr_i = adr; a.dat_i = dat;
      @(posedge clk); #1;
      l = 0;
      while (!(a.ack_o || err_a) && l < 20) begin
         @(posedge clk); #1;
         l++;
      end
      r = a.dat_o;
      @(posedge clk); #1;
      ack_again = a.ack_o;
      @(negedge clk);
      a.cyc_i = 1'b0; a.stb_i = 1'b0;
   endtask
   task automatic xfer_b(input logic w, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] r, output int l);
      @(negedge clk);
      b.cyc_i = 1'b1; b.stb_i = 1'b1; b.we_i = w; b.adr_i = adr; b.dat_i = dat;
      @(posedge clk); #1;
      l = 0;
      while (!b.ack_o && l < 20) begin
         @(posedge clk); #1;
         l++;
      end
      r = b.dat_o;
      @(negedge clk);
      b.cyc_i = 1'b0; b.stb_i = 1'b0;
   endtask
   initial begin
      a.cyc_i = 0; a.stb_i = 0; a.we_i = 0; a.adr_i = 0; a.dat_i = 0;
      b.cyc_i = 0; b.stb_i = 0; b.we_i = 0; b.adr_i = 0; b.dat_i = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(a.ack_o), 32'd0);
      check("rst_dat", a.dat_o, 32'd0);
      check("rst_cnt", 32'(cnt_a), 32'd0);
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         xfer(1'b1, 32'(i), 32'(i) * 32'h11111111, rd, lat, ack2);
         xfer(1'b0, 32'(i), 32'h0, rd, lat, ack2);
         check($sformatf("seq_rd%0d", i), rd, 32'(i) * 32'h11111111);
      end
      check("seq_cnt", 32'(cnt_a), 32'd32);
      xfer(1'b1, 32'd3, 32'h33333333, rd, lat, ack2);
      check("wr3_lat", 32'(lat), 32'd2);
      check("wr3_width", 32'(ack2), 32'd0);
      xfer(1'b0, 32'd3, 32'h0, rd, lat, ack2);
      check("rd3_lat", 32'(lat), 32'd2);
      check("rd3_dat", rd, 32'h33333333);
      check("cnt34", 32'(cnt_a), 32'd34);
      xfer(1'b1, 32'd20, 32'hA5A5A5A5, rd, lat, ack2);
`ifdef WB_SLAVE_ERR_EN
      check("oor_errs", 32'(errs_a), 32'd1);
      check("oor_acks", 32'(acks_a), 32'd34);
      check("oor_cnt", 32'(cnt_a), 32'd34);
      check("oor_dat", a.dat_o, 32'd0);
      exp4 = 32'h44444444;
      xfer(1'b0, 32'd4, 32'h0, rd, lat, ack2);
      check("oor_word4", rd, exp4);
`else
      check("alias_lat", 32'(lat), 32'd2);
      check("alias_cnt", 32'(cnt_a), 32'd35);
      exp4 = 32'hA5A5A5A5;
      xfer(1'b0, 32'd4, 32'h0, rd, lat, ack2);
      check("alias_word4", rd, exp4);
`endif
      @(negedge clk);
      a.cyc_i = 1'b1; a.stb_i = 1'b1; a.we_i = 1'b0; a.adr_i = 32'd4;
      @(posedge clk); #1;
      lat = 0;
      while (!a.ack_o && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      ack2 = 1'b0;
      check("hold_dat", a.dat_o, exp4);
      lat = acks_a;
      repeat (5) begin
         @(posedge clk); #1;
         ack2 = ack2 | a.ack_o;
      end
      check("hold_reack", 32'(ack2), 32'd0);
      check("hold_acks", 32'(acks_a - lat), 32'd0);
      check("hold_state", 32'(dut.state), 32'd3);
      @(negedge clk);
      a.cyc_i = 1'b0; a.stb_i = 1'b0;
      @(posedge clk); #1;
      check("hold_idle", 32'(dut.state), 32'd0);
      @(negedge clk);
      b.cyc_i = 1'b1; b.stb_i = 1'b1; b.we_i = 1'b1; b.adr_i = 32'd2; b.dat_i = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      b.stb_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort_acks", 32'(acks_b), 32'd0);
      check("abort_cnt", 32'(cnt_b), 32'd0);
      xfer_b(1'b0, 32'd2, 32'h0, rd, lat);
      check("abort_word2", rd, 32'd0);
      check("b_lat", 32'(lat), 32'd5);
      check("b_cnt", 32'(cnt_b), 32'd1);
      lat = acks_a;
      @(negedge clk);
      a.cyc_i = 1'b1; a.stb_i = 1'b1; a.we_i = 1'b1; a.adr_i = 32'd1; a.dat_i = 32'h77777777;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      a.cyc_i = 1'b0; a.stb_i = 1'b0;
      @(negedge clk) rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rstw_acks", 32'(acks_a - lat), 32'd0);
      check("rstw_dat", a.dat_o, 32'd0);
      check("rstw_cnt", 32'(cnt_a), 32'd0);
      xfer(1'b0, 32'd0, 32'h0, rd, lat, ack2);
      check("rstw_rd0", rd, 32'd0);
      xfer(1'b0, 32'd1, 32'h0, rd, lat, ack2);
      check("rstw_rd1", rd, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 Parameter DEPTH, default 16, number of DATA_WIDTH-bit words; power of two, 2..256.
REQ-004 Parameter WAIT_CYCLES, default 1, wait states inserted before ack, 0..15.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cyc_i  in  1  Wishbone bus cycle valid.
REQ-008 stb_i  in  1  Wishbone strobe.
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 adr_i  in  ADDR_WIDTH  word address.
REQ-011 dat_i  in  DATA_WIDTH  write data.
REQ-012 dat_o  out  DATA_WIDTH  read data, registered.
REQ-013 ack_o  out  1  transfer acknowledge, registered, one-cycle pulse.
REQ-014 err_o  out  1  error acknowledge, registered pulse; present only with WB_SLAVE_ERR_EN.
REQ-015 access_count  out  16  completed-transfer counter.

Function
REQ-016 FSM states: S_IDLE, S_WAIT, S_ACK, S_RELEASE; reset state S_IDLE.
REQ-017 S_IDLE: cyc_i&stb_i sampled high -> latch adr_i, we_i, dat_i; go to S_WAIT if WAIT_CYCLES>0, else S_ACK; load wait counter with WAIT_CYCLES-1.
REQ-018 S_WAIT: decrement counter each cycle; counter 0 -> S_ACK.
REQ-019 Transition into S_ACK drives ack_o=1 (or err_o=1, see REQ-028) for exactly one cycle; next state S_RELEASE.
REQ-020 Latency: ack_o rises WAIT_CYCLES+1 edges after the edge that samples the request.
REQ-021 Write: memory word adr[log2(DEPTH)-1:0] updated with latched dat_i on the same edge ack_o rises.
REQ-022 Read: dat_o loaded with addressed word on the same edge ack_o rises; dat_o holds value until next read ack.
REQ-023 S_RELEASE: stay while stb_i=1; stb_i=0 -> S_IDLE; a held strobe is never acknowledged twice.
REQ-024 Abort: cyc_i=0 or stb_i=0 in S_WAIT -> S_IDLE, no memory write, no ack_o, no count.
REQ-025 access_count increments by 1 on each ack_o; wraps 0xFFFF -> 0x0000; err_o does not count.
REQ-026 Without WB_SLAVE_ERR_EN, out-of-range addresses (adr_i >= DEPTH) alias to the low log2(DEPTH) bits and are acknowledged normally.
REQ-027 Read-after-write to same address in consecutive transfers returns the newly written value.

Configuration
REQ-028 Macro WB_SLAVE_ERR_EN defined: adr_i >= DEPTH -> err_o pulse in place of ack_o, no memory write, dat_o set to 0, access_count unchanged; FSM timing identical to ack path.
REQ-029 Macro WB_SLAVE_ERR_EN undefined: err_o port absent; behaviour per REQ-026.

Reset
REQ-030 rst=0 asynchronously forces: state S_IDLE, ack_o=0, err_o=0, dat_o=0, access_count=0, wait counter=0, all memory words=0.
REQ-031 Reset asserted mid-transfer discards the transfer; no ack_o after rst returns to 1 unless a new strobe is sampled.

Verification
REQ-032 WAIT_CYCLES=1: write adr 3, dat 0x33333333 -> ack_o high 2 edges after sampling, one cycle wide; read adr 3 -> dat_o=0x33333333 with ack_o.
REQ-033 Sequential test: 16 write/read pairs, adr 0..15, data 0x00000000..0xFFFFFFFF step 0x11111111 -> all reads match, access_count=32.
REQ-034 Strobe held 5 cycles after ack_o -> exactly one ack_o, state returns S_IDLE only after stb_i=0.
REQ-035 Drop stb_i during S_WAIT with WAIT_CYCLES=4, write adr 2 dat 0xDEADBEEF -> no ack_o, word 2 unchanged, access_count unchanged.
REQ-036 With WB_SLAVE_ERR_EN, write adr 20 -> err_o pulse, no ack_o, memory unchanged; without macro, write adr 20 -> ack_o, word 4 updated.
REQ-037 rst pulsed low during S_WAIT -> ack_o never asserts, dat_o=0, access_count=0, read adr 0 afterwards returns 0.
